// File: rtl/adc_frame_packer.sv
// adc_frame_packer: packs one 8-channel 18-bit ADC conversion set into a
// 28-byte UART frame: HDR0 HDR1 SEQ, 24 payload bytes, CSUM.
// Ports:
//   clk, rst        - rising-edge clock, async active-high reset
//   smp_valid       - pulse: ad_ch1..ad_ch8 carry a new conversion set
//   ad_ch1..ad_ch8  - 18-bit raw channel samples
//   tx_data/valid   - frame byte toward the transmitter (valid/ready)
//   tx_ready        - transmitter accepts tx_data this cycle
//   busy            - frame in progress
//   drop_cnt        - saturating count of samples discarded while busy
module adc_frame_packer #(
  parameter logic [7:0] HDR0 = 8'hA5,
  parameter logic [7:0] HDR1 = 8'h5A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        smp_valid,
  input  logic [17:0] ad_ch1,
  input  logic [17:0] ad_ch2,
  input  logic [17:0] ad_ch3,
  input  logic [17:0] ad_ch4,
  input  logic [17:0] ad_ch5,
  input  logic [17:0] ad_ch6,
  input  logic [17:0] ad_ch7,
  input  logic [17:0] ad_ch8,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    CSUM
  } state_t;

  state_t       state;
  logic [1:0]   hcnt;
  logic [4:0]   pcnt;
  logic [7:0]   seq;
  logic [7:0]   csum;
  logic [191:0] pay;

  logic         fire;
  logic         last;
  logic         cap;
  logic         drop;
  logic [7:0]   csum_nxt;
  logic [191:0] snap;

  assign fire     = tx_valid & tx_ready;
  assign last     = (state == CSUM) & fire;
  assign cap      = smp_valid & ((state == IDLE) | last);
  assign drop     = smp_valid & ~cap;
  assign csum_nxt = csum + tx_data;

  // Snapshot laid out in send order; each channel is padded to 3 bytes
  // so the payload drains as a plain byte shift from the top.
  assign snap = {6'b0, ad_ch1, 6'b0, ad_ch2,
                 6'b0, ad_ch3, 6'b0, ad_ch4,
                 6'b0, ad_ch5, 6'b0, ad_ch6,
                 6'b0, ad_ch7, 6'b0, ad_ch8};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hcnt     <= '0;
      pcnt     <= '0;
      seq      <= '0;
      csum     <= '0;
      pay      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;

      if (last)
        seq <= seq + 8'd1;

      if (cap) begin
        pay      <= snap;
        state    <= HDR;
        hcnt     <= '0;
        tx_data  <= HDR0;
        tx_valid <= 1'b1;
        busy     <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
          end
          HDR: begin
            if (fire) begin
              unique case (hcnt)
                2'd0: begin
                  tx_data <= HDR1;
                  hcnt    <= 2'd1;
                end
                2'd1: begin
                  // seq already advanced if this frame started back-to-back
                  tx_data <= seq;
                  hcnt    <= 2'd2;
                end
                default: begin
                  state   <= PAYLOAD;
                  tx_data <= pay[191:184];
                  pcnt    <= '0;
                  csum    <= seq;
                end
              endcase
            end
          end
          PAYLOAD: begin
            if (fire) begin
              csum <= csum_nxt;
              if (pcnt == 5'd23) begin
                state   <= CSUM;
                tx_data <= csum_nxt;
              end else begin
                pay     <= pay << 8;
                tx_data <= pay[183:176];
                pcnt    <= pcnt + 5'd1;
              end
            end
          end
          CSUM: begin
            if (fire) begin
              state    <= IDLE;
              tx_data  <= '0;
              tx_valid <= 1'b0;
              busy     <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// tb_adc_frame_packer: randomized self-checking bench for adc_frame_packer
// against a frame-level reference model.
module tb_adc_frame_packer;

  typedef logic [7:0] u8;
  localparam u8 H0 = 8'hA5;
  localparam u8 H1 = 8'h5A;

  logic        clk;
  logic        rst;
  logic        smp_valid;
  logic        tx_ready;
  logic        tx_valid;
  logic        busy;
  logic [17:0] ch [8];
  logic [7:0]  tx_data;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  u8  model_seq;

  adc_frame_packer #(.HDR0(8'hA5), .HDR1(8'h5A)) dut (
    .clk(clk), .rst(rst), .smp_valid(smp_valid),
    .ad_ch1(ch[0]), .ad_ch2(ch[1]), .ad_ch3(ch[2]), .ad_ch4(ch[3]),
    .ad_ch5(ch[4]), .ad_ch6(ch[5]), .ad_ch7(ch[6]), .ad_ch8(ch[7]),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference frame from the byte-level definition of the format.
  function automatic void build(input u8 s, input logic [17:0] c [8],
                                output u8 f[$]);
    int sum;
    int w;
    f = {};
    f.push_back(H0);
    f.push_back(H1);
    f.push_back(s);
    sum = int'(s);
    for (int k = 0; k < 8; k++) begin
      w = int'(c[k]);
      f.push_back(u8'(w / 65536));
      f.push_back(u8'((w / 256) % 256));
      f.push_back(u8'(w % 256));
      sum = sum + w / 65536 + (w / 256) % 256 + w % 256;
    end
    f.push_back(u8'(sum % 256));
  endfunction

  function automatic int diff_count(input u8 a[$], input u8 b[$]);
    int n = 0;
    if (a.size() != b.size()) return 1000;
    foreach (a[i]) if (a[i] !== b[i]) n++;
    return n;
  endfunction

  task automatic rand_set(output logic [17:0] c [8]);
    for (int i = 0; i < 8; i++) c[i] = 18'($urandom);
  endtask

  task automatic scramble();
    for (int i = 0; i < 8; i++) ch[i] = 18'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    smp_valid = 1'b0;
    tx_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_seq = 8'h00;
  endtask

  task automatic capture(input logic [17:0] c [8]);
    ch = c;
    smp_valid = 1'b1;
    tick();
    smp_valid = 1'b0;
    scramble();
  endtask

  // Drives tx_ready and collects transferred bytes until stop_at bytes
  // have moved; records stall instability and valid gaps.
  task automatic collect(input int ready_pct, input int stop_at,
                         input int drop_lo, input int drop_n,
                         input bit b2b, output u8 got[$],
                         output int stall_bad, output int gaps,
                         output bit tmo);
    logic pv;
    logic pr;
    u8    pd;
    int   left;
    bit   pulsed;
    got = {};
    stall_bad = 0;
    gaps = 0;
    pv = 1'b0;
    pr = 1'b0;
    pd = 8'h00;
    left = drop_n;
    pulsed = 1'b0;
    for (int cyc = 0; cyc < 4000 && got.size() < stop_at; cyc++) begin
      logic v;
      logic r;
      u8    d;
      v = tx_valid;
      d = tx_data;
      if (pv && !pr && (v !== 1'b1 || d !== pd)) stall_bad++;
      if (v !== 1'b1) gaps++;
      r = (int'($urandom_range(99)) < ready_pct);
      tx_ready = r;
      smp_valid = 1'b0;
      if (left > 0 && !pulsed && got.size() >= drop_lo) begin
        smp_valid = 1'b1;
        left--;
        pulsed = 1'b1;
        scramble();
      end else begin
        pulsed = 1'b0;
      end
      if (v === 1'b1 && r) begin
        got.push_back(d);
        if (b2b && got.size() == stop_at) smp_valid = 1'b1;
      end
      pv = v;
      pr = r;
      pd = d;
      tick();
    end
    smp_valid = 1'b0;
    tx_ready = 1'b0;
    tmo = (got.size() < stop_at);
  endtask

  task automatic test_reset();
    logic [17:0] c [8];
    u8  got[$];
    u8  exp[$];
    int sb, gp;
    bit tmo;
    rst = 1'b1;
    tx_ready = 1'b0;
    rand_set(c);
    ch = c;
    smp_valid = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tx_valid: got %b want 0", tx_valid);
    end
    n_checks++;
    if (tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_tx_data: got %h want 00", tx_data);
    end
    n_checks++;
    if (busy !== 1'b0 || drop_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_busy_drop: got %b/%h want 0/00", busy, drop_cnt);
    end
    rst = 1'b0;
    tick();
    smp_valid = 1'b0;
    scramble();
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== H0) begin
      n_fail++;
      $display("FAIL release_capture: got %b/%h want 1/%h",
               tx_valid, tx_data, H0);
    end
    model_seq = 8'h00;
    collect(100, 28, 0, 0, 0, got, sb, gp, tmo);
    build(model_seq, c, exp);
    n_checks++;
    if (tmo || diff_count(got, exp) != 0) begin
      n_fail++;
      $display("FAIL release_frame: %0d bytes differ, tmo %0d",
               diff_count(got, exp), tmo);
    end
    model_seq++;
  endtask

  task automatic test_basic();
    logic [17:0] c [8];
    u8  got[$];
    u8  exp[$];
    int sb, gp;
    bit tmo;
    do_reset();
    for (int i = 0; i < 8; i++) c[i] = 18'h0;
    c[0] = 18'h3FFFF;
    c[1] = 18'h00001;
    capture(c);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== H0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_latency: got %b/%h/%b want 1/a5/1",
               tx_valid, tx_data, busy);
    end
    collect(100, 28, 0, 0, 0, got, sb, gp, tmo);
    exp = {8'hA5, 8'h5A, 8'h00, 8'h03, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01};
    for (int i = 0; i < 18; i++) exp.push_back(8'h00);
    exp.push_back(8'h02);
    n_checks++;
    if (tmo || diff_count(got, exp) != 0) begin
      n_fail++;
      $display("FAIL basic_frame: %0d bytes differ, tmo %0d",
               diff_count(got, exp), tmo);
    end
    n_checks++;
    if (gp != 0) begin
      n_fail++;
      $display("FAIL basic_no_bubble: got %0d gaps want 0", gp);
    end
    n_checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL basic_end_idle: got %b/%b/%h want 0/0/00",
               tx_valid, busy, tx_data);
    end
    model_seq++;
  endtask

  task automatic test_backpressure();
    logic [17:0] c [8];
    u8  got[$];
    u8  exp[$];
    int sb, gp, bad, unstable;
    bit tmo;
    bad = 0;
    unstable = 0;
    for (int f = 0; f < 3; f++) begin
      rand_set(c);
      capture(c);
      collect(40, 28, 0, 0, 0, got, sb, gp, tmo);
      build(model_seq, c, exp);
      if (tmo || diff_count(got, exp) != 0) bad++;
      unstable += sb;
      model_seq++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_frames: got %0d bad frames want 0", bad);
    end
    n_checks++;
    if (unstable != 0) begin
      n_fail++;
      $display("FAIL bp_stall_stable: got %0d changes want 0", unstable);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] c1 [8];
    logic [17:0] c2 [8];
    u8  got[$];
    u8  exp[$];
    u8  d0;
    int sb, gp;
    bit tmo;
    rand_set(c1);
    rand_set(c2);
    capture(c1);
    ch = c2;
    d0 = drop_cnt;
    collect(100, 28, 0, 0, 1, got, sb, gp, tmo);
    scramble();
    build(model_seq, c1, exp);
    n_checks++;
    if (tmo || diff_count(got, exp) != 0) begin
      n_fail++;
      $display("FAIL b2b_frame1: %0d bytes differ", diff_count(got, exp));
    end
    model_seq++;
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== H0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_next_hdr: got %b/%h/%b want 1/a5/1",
               tx_valid, tx_data, busy);
    end
    n_checks++;
    if (drop_cnt !== d0) begin
      n_fail++;
      $display("FAIL b2b_drop_cnt: got %h want %h", drop_cnt, d0);
    end
    collect(100, 28, 0, 0, 0, got, sb, gp, tmo);
    build(model_seq, c2, exp);
    n_checks++;
    if (tmo || diff_count(got, exp) != 0) begin
      n_fail++;
      $display("FAIL b2b_frame2: %0d bytes differ, seq %h want %h",
               diff_count(got, exp), got.size() > 2 ? got[2] : 8'h00,
               model_seq);
    end
    model_seq++;
  endtask

  task automatic test_drops();
    logic [17:0] c [8];
    u8  got[$];
    u8  exp[$];
    u8  d0;
    int sb, gp;
    bit tmo;
    rand_set(c);
    capture(c);
    d0 = drop_cnt;
    collect(100, 28, 5, 3, 0, got, sb, gp, tmo);
    build(model_seq, c, exp);
    n_checks++;
    if (drop_cnt !== u8'(d0 + 8'd3)) begin
      n_fail++;
      $display("FAIL drop_count3: got %h want %h", drop_cnt, u8'(d0 + 8'd3));
    end
    n_checks++;
    if (tmo || diff_count(got, exp) != 0) begin
      n_fail++;
      $display("FAIL drop_frame: %0d bytes differ", diff_count(got, exp));
    end
    model_seq++;
    rand_set(c);
    capture(c);
    tx_ready = 1'b0;
    for (int i = 0; i < 600; i++) begin
      smp_valid = (i % 2 == 0);
      if (smp_valid) scramble();
      tick();
    end
    smp_valid = 1'b0;
    n_checks++;
    if (drop_cnt !== 8'hFF) begin
      n_fail++;
      $display("FAIL drop_saturate: got %h want ff", drop_cnt);
    end
    collect(100, 28, 0, 0, 0, got, sb, gp, tmo);
    build(model_seq, c, exp);
    n_checks++;
    if (tmo || diff_count(got, exp) != 0) begin
      n_fail++;
      $display("FAIL drop_sat_frame: %0d bytes differ", diff_count(got, exp));
    end
    model_seq++;
  endtask

  task automatic test_seq_wrap();
    logic [17:0] c [8];
    u8  got[$];
    u8  exp[$];
    int sb, gp, bad;
    bit tmo;
    do_reset();
    bad = 0;
    for (int f = 1; f <= 257; f++) begin
      rand_set(c);
      capture(c);
      collect(100, 28, 0, 0, 0, got, sb, gp, tmo);
      build(model_seq, c, exp);
      if (tmo || diff_count(got, exp) != 0) bad++;
      if (f == 256) begin
        n_checks++;
        if (got.size() < 3 || got[2] !== 8'hFF) begin
          n_fail++;
          $display("FAIL seq_frame256: got %h want ff",
                   got.size() > 2 ? got[2] : 8'h00);
        end
      end
      if (f == 257) begin
        n_checks++;
        if (got.size() < 3 || got[2] !== 8'h00) begin
          n_fail++;
          $display("FAIL seq_frame257: got %h want 00",
                   got.size() > 2 ? got[2] : 8'hEE);
        end
      end
      model_seq++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL seq_frames: got %0d bad frames want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    logic [17:0] c [8];
    u8  got[$];
    u8  exp[$];
    int sb, gp;
    bit tmo;
    rand_set(c);
    capture(c);
    collect(100, 10, 0, 0, 0, got, sb, gp, tmo);
    rst = 1'b1;
    #1;
    n_checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: got %b/%h/%b want 0/00/0",
               tx_valid, tx_data, busy);
    end
    tick();
    rst = 1'b0;
    model_seq = 8'h00;
    rand_set(c);
    capture(c);
    collect(100, 28, 0, 0, 0, got, sb, gp, tmo);
    build(model_seq, c, exp);
    n_checks++;
    if (tmo || got.size() < 3 || got[0] !== H0 || got[1] !== H1 ||
        got[2] !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_header: size %0d tmo %0d want a5 5a 00",
               got.size(), tmo);
    end
    n_checks++;
    if (diff_count(got, exp) != 0) begin
      n_fail++;
      $display("FAIL rst_mid_frame: %0d bytes differ", diff_count(got, exp));
    end
    n_checks++;
    if (drop_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_drop: got %h want 00", drop_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    smp_valid = 1'b0;
    tx_ready = 1'b0;
    model_seq = 8'h00;
    for (int i = 0; i < 8; i++) ch[i] = 18'h0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_drops();
    test_seq_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
